// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with zero entry, clear sweep and optional RF_BYPASS_EN forwarding
module regfile_mp #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  input  logic                     wr_en,
  input  logic [ADDR_W-1:0]        wr_addr,
  input  logic [DATA_W-1:0]        wr_data,
  input  logic                     clr_req,
  output logic                     busy
);
  localparam int DEPTH = 2 ** ADDR_W;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [DATA_W-1:0] mem [1:DEPTH-1];
  logic [DATA_W-1:0] rd_next [NUM_RD];
  logic [ADDR_W-1:0] ra;
  logic              wr_ok;
  assign wr_ok = wr_en && wr_addr != '0;
  assign busy = (state == CLEAR) | reset;
  // next read value per port: zero for entry 0, optionally forwarded write data, else array contents
  always_comb begin
    ra = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      ra = rd_addr[p*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
      rd_next[p] = ra == '0 ? '0 : (wr_ok && wr_addr == ra) ? wr_data : mem[ra];
`else
      rd_next[p] = ra == '0 ? '0 : mem[ra];
`endif
    end
  end
  // clear sweep FSM, array writes and registered read ports; the sweep never touches entry 0
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= CLEAR;
      cnt     <= ADDR_W'(1);
      rd_data <= '0;
    end else if (state == CLEAR) begin
      mem[cnt] <= '0;
      cnt      <= cnt + 1'b1;
      state    <= cnt == '1 ? IDLE : CLEAR;
      rd_data  <= '0;
    end else begin
      if (wr_ok) mem[wr_addr] <= wr_data;
      if (clr_req) begin
        state <= CLEAR;
        cnt   <= ADDR_W'(1);
      end
      for (int p = 0; p < NUM_RD; p++) rd_data[p*DATA_W +: DATA_W] <= rd_next[p];
    end
  end
endmodule
